// File: rtl/ascon_aead128_pkg.sv
// rtl/ascon_aead128_pkg.sv - shared types and constants for the ASCON-AEAD128 datapath
package ascon_aead128_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        HOLD  = 2'd1,
        EXTRA = 2'd2
    } buf_state_t;

    localparam logic [7:0] PAD_BYTE = 8'h01;

endpackage

// File: rtl/data_reg.sv
// rtl/data_reg.sv - enable-loaded register with synchronous clear and async active-low reset
module data_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear wins over load so a dropped block never leaks a stale word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/word_pad.sv
// rtl/word_pad.sv - masks bytes beyond the message end and inserts the 10* pad byte
import ascon_aead128_pkg::*;

module word_pad #(
    parameter int WORD_W = 32
) (
    input  logic [WORD_W-1:0]                 word,
    input  logic [$clog2(WORD_W/8+1)-1:0]     nbytes,
    input  logic                              last,
    output logic [WORD_W-1:0]                 padded
);

    localparam int NBYTES = WORD_W / 8;

    // Non-final words pass unchanged; a final word keeps nbytes bytes, then the pad byte.
    always_comb begin
        padded = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (!last || i < int'(nbytes))
                padded[8*i +: 8] = word[8*i +: 8];
            else if (i == int'(nbytes))
                padded[8*i +: 8] = PAD_BYTE;
        end
    end

endmodule

// File: rtl/ascon_block_buffer.sv
// rtl/ascon_block_buffer.sv - collects input words into padded rate blocks for the permutation
import ascon_aead128_pkg::*;

module ascon_block_buffer #(
    parameter int WORD_W = 32,
    parameter int WORDS  = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   clr,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [WORD_W-1:0]                      in_data,
    input  logic [$clog2(WORD_W/8+1)-1:0]          in_bytes,
    input  logic                                   in_last,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [WORD_W*WORDS-1:0]                out_data,
    output logic [$clog2(WORD_W*WORDS/8+1)-1:0]    out_bytes,
    output logic                                   out_last
);

    localparam int NBYTES = WORD_W / 8;
    localparam int OB_W   = $clog2(WORD_W*WORDS/8 + 1);
    localparam int CW     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST_SLOT = CW'(WORDS - 1);

    buf_state_t        state;
    logic [CW-1:0]     wcnt;
    logic              pad_pending;
    logic              accept;
    logic              block_done;
    logic              full_final;
    logic [OB_W-1:0]   fill_bytes;
    logic [WORD_W-1:0] padded;
    logic              to_extra;
    logic              slot_clr;

    assign in_ready   = (state == FILL) && !clr;
    assign out_valid  = (state == HOLD) || (state == EXTRA);
    assign accept     = in_valid && in_ready;
    assign block_done = in_last || (wcnt == LAST_SLOT);
    assign full_final = in_last && (wcnt == LAST_SLOT) && (in_bytes == ($clog2(NBYTES+1))'(NBYTES));
    assign fill_bytes = OB_W'(NBYTES) * OB_W'(wcnt)
                      + (in_last ? OB_W'(in_bytes) : OB_W'(NBYTES));
    assign to_extra   = (state == HOLD) && out_ready && pad_pending && !clr;
    assign slot_clr   = clr
                      || ((state == HOLD) && out_ready && !pad_pending)
                      || ((state == EXTRA) && out_ready);

    word_pad #(.WORD_W(WORD_W)) u_pad (
        .word   (in_data),
        .nbytes (in_bytes),
        .last   (in_last),
        .padded (padded)
    );

    for (genvar k = 0; k < WORDS; k++) begin : g_slot
        logic              en;
        logic [WORD_W-1:0] d;
        logic [WORD_W-1:0] q;

        // The padding-only block reuses the slots: pad byte in slot 0, zeros elsewhere.
        assign en = (accept && (wcnt == CW'(k))) || to_extra;
        assign d  = to_extra ? ((k == 0) ? WORD_W'(PAD_BYTE) : '0) : padded;

        data_reg #(.WIDTH(WORD_W)) u_reg (
            .clk (clk),
            .rst (rst),
            .clr (slot_clr),
            .en  (en),
            .d   (d),
            .q   (q)
        );

        assign out_data[WORD_W*k +: WORD_W] = q;
    end

    // Block sequencing: fill slots, hold the block, then optionally emit the pad-only block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= FILL;
            wcnt        <= '0;
            pad_pending <= 1'b0;
            out_bytes   <= '0;
            out_last    <= 1'b0;
        end else if (clr) begin
            state       <= FILL;
            wcnt        <= '0;
            pad_pending <= 1'b0;
            out_bytes   <= '0;
            out_last    <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        if (block_done) begin
                            state       <= HOLD;
                            out_bytes   <= fill_bytes;
                            pad_pending <= full_final;
                            out_last    <= in_last && !full_final;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        wcnt        <= '0;
                        pad_pending <= 1'b0;
                        if (pad_pending) begin
                            state     <= EXTRA;
                            out_bytes <= '0;
                            out_last  <= 1'b1;
                        end else begin
                            state     <= FILL;
                            out_bytes <= '0;
                            out_last  <= 1'b0;
                        end
                    end
                end
                EXTRA: begin
                    if (out_ready) begin
                        state     <= FILL;
                        wcnt      <= '0;
                        out_bytes <= '0;
                        out_last  <= 1'b0;
                    end
                end
                default: begin
                    state <= FILL;
                    wcnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_block_buffer.sv
// tb/tb_ascon_block_buffer.sv - directed self-checking bench for ascon_block_buffer
module tb_ascon_block_buffer;

    logic         clk = 1'b0;
    logic         rst;
    logic         clr;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic [2:0]   in_bytes;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [4:0]   out_bytes;
    logic         out_last;

    int vectors = 0;
    int errs    = 0;
    logic [127:0] held;

    ascon_block_buffer #(.WORD_W(32), .WORDS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_bytes  (in_bytes),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_bytes (out_bytes),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic [2:0] nb, input logic last);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_bytes = nb;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic take();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0;
        in_bytes = '0; in_last = 1'b0; out_ready = 1'b0;
        #12;
        chk("reset_valid", out_valid, 0);
        chk("reset_data", out_data, 0);
        chk("reset_bytes", out_bytes, 0);
        chk("reset_last", out_last, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("reset_in_ready", in_ready, 1);

        // four full words, no last
        send(32'h03020100, 3'd4, 1'b0);
        send(32'h07060504, 3'd4, 1'b0);
        send(32'h0B0A0908, 3'd4, 1'b0);
        chk("full_partial_valid", out_valid, 0);
        send(32'h0F0E0D0C, 3'd4, 1'b0);
        chk("full_valid", out_valid, 1);
        chk("full_data", out_data, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
        chk("full_bytes", out_bytes, 16);
        chk("full_last", out_last, 0);
        chk("full_in_ready", in_ready, 0);
        take();
        chk("full_after_in_ready", in_ready, 1);
        chk("full_after_valid", out_valid, 0);

        // message ends exactly on a block boundary
        send(32'h03020100, 3'd4, 1'b0);
        send(32'h07060504, 3'd4, 1'b0);
        send(32'h0B0A0908, 3'd4, 1'b0);
        send(32'h0F0E0D0C, 3'd4, 1'b1);
        chk("bnd_data", out_data, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
        chk("bnd_bytes", out_bytes, 16);
        chk("bnd_last", out_last, 0);
        take();
        chk("extra_valid", out_valid, 1);
        chk("extra_data", out_data, 128'h01);
        chk("extra_bytes", out_bytes, 0);
        chk("extra_last", out_last, 1);
        take();
        chk("extra_done_valid", out_valid, 0);

        // partial final word
        send(32'h44332211, 3'd4, 1'b0);
        send(32'hDDCCBBAA, 3'd3, 1'b1);
        chk("part_valid", out_valid, 1);
        chk("part_data", out_data, 128'h00000000_00000000_01CCBBAA_44332211);
        chk("part_bytes", out_bytes, 7);
        chk("part_last", out_last, 1);
        take();
        chk("part_no_extra", out_valid, 0);

        // empty message
        send(32'hFFFFFFFF, 3'd0, 1'b1);
        chk("empty_data", out_data, 128'h01);
        chk("empty_bytes", out_bytes, 0);
        chk("empty_last", out_last, 1);
        take();
        chk("empty_no_extra", out_valid, 0);

        // backpressure with in_valid held high
        send(32'hA0A1A2A3, 3'd4, 1'b0);
        send(32'hB0B1B2B3, 3'd4, 1'b0);
        send(32'hC0C1C2C3, 3'd4, 1'b0);
        send(32'hD0D1D2D3, 3'd4, 1'b0);
        held = 128'hD0D1D2D3_C0C1C2C3_B0B1B2B3_A0A1A2A3;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h55555555;
        in_bytes = 3'd2;
        in_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_data", out_data, held);
            chk("bp_bytes", out_bytes, 16);
            chk("bp_last", out_last, 0);
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        take();
        chk("bp_release", out_valid, 0);

        // clear drops a partial block
        send(32'h00000001, 3'd4, 1'b0);
        send(32'h00000002, 3'd4, 1'b0);
        @(negedge clk);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h99999999;
        #1;
        chk("clr_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        chk("clr_valid", out_valid, 0);
        send(32'h00000010, 3'd4, 1'b0);
        send(32'h00000020, 3'd4, 1'b0);
        send(32'h00000030, 3'd4, 1'b0);
        send(32'h00000040, 3'd4, 1'b0);
        chk("clr_data", out_data, 128'h00000040_00000030_00000020_00000010);

        // asynchronous reset while holding a block
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_in_ready", in_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/ascon_block_buffer.md
Name: ascon_block_buffer

Overview:
- Parametrised successor to data_reg: collects WORD_W-bit input words into one WORDS*WORD_W-bit block and applies ASCON-AEAD128 10* padding.
- Sits between the AD/plaintext input interface and the permutation datapath. Presents complete 128-bit rate blocks by default.
- Valid/ready handshakes on both sides. Inserts the extra padding-only block when a message ends exactly on a block boundary.

Parameters:
- WORD_W, 32, input word width in bits; must be a multiple of 8.
- WORDS, 4, words per output block; must be >= 1. Block width is BLK_W = WORD_W*WORDS, 128 by default.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear; drops any partial or held block.
- in_valid  input  1  input word valid.
- in_ready  output  1  buffer accepts a word this cycle.
- in_data  input  WORD_W  input word; byte i is in_data[8i+7:8i] (little-endian).
- in_bytes  input  $clog2(WORD_W/8+1)  number of valid bytes in in_data, 0..WORD_W/8.
- in_last  input  1  this word ends the message.
- out_valid  output  1  block available.
- out_ready  input  1  consumer takes the block.
- out_data  output  BLK_W  padded block; word k is out_data[WORD_W*k +: WORD_W].
- out_bytes  output  $clog2(BLK_W/8+1)  number of message bytes in the block, excluding padding.
- out_last  output  1  final block of the message.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=FILL, word counter wcnt=0, internal buffer=0.
  - Outputs: out_valid=0, out_data=0, out_bytes=0, out_last=0, pad_pending=0.
  - Asserting rst mid-operation discards all data.
- FSM states: FILL, HOLD, EXTRA.
- in_ready = (state==FILL) && !clr. A word is accepted on in_valid && in_ready.
- out_valid=1 exactly in HOLD and EXTRA. All outputs are registered.
- FILL, on accept:
  - The word is written to slot wcnt.
  - If in_last=1: bytes >= in_bytes are zeroed, byte in_bytes gets 8'h01 if in_bytes < WORD_W/8, and higher slots stay 0.
  - If in_last=0: in_bytes is ignored and the word is treated as full.
  - If wcnt==WORDS-1 or in_last, go to HOLD on the next edge; otherwise wcnt++.
- Latency: out_valid rises one cycle after the accepting edge.
- HOLD:
  - out_data shows the block; out_bytes = WORD_W/8*wcnt + effective bytes of the final word.
  - pad_pending = in_last && wcnt==WORDS-1 && in_bytes==WORD_W/8. In that case no pad byte fits in the block.
  - out_last = in_last && !pad_pending.
  - On out_ready: go to EXTRA if pad_pending, else go to FILL with wcnt=0 and buffer=0.
- EXTRA:
  - out_data = {0, 8'h01} (8'h01 in byte 0), out_bytes=0, out_last=1.
  - On out_ready: go to FILL.
- Stability: while out_valid=1 and out_ready=0, out_data, out_bytes and out_last hold stable. in_valid is ignored.
- Empty message (in_last with in_bytes=0 at wcnt=0): block = 8'h01 in byte 0, out_bytes=0, out_last=1.
- clr=1 (any state):
  - Next edge: state=FILL, wcnt=0, buffer=0, out_valid=0, pad_pending=0.
  - clr has priority over a simultaneous in_valid (no accept) and over out_ready.
- No input bypass while HOLD/EXTRA; throughput is WORDS+1 cycles per block at best.

Decomposition:
- ascon_aead128_pkg additions: buf_state_t enum {FILL, HOLD, EXTRA}; constant PAD_BYTE=8'h01.
- One combinational sub-module, word_pad. Ports: word, nbytes, last → padded word. It performs the byte masking and pad-byte insertion.
- Block storage is WORDS instances of the existing data_reg (WIDTH=WORD_W), one enable per slot.

Test Plan:
- Four full words with in_last=0: 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C → one cycle later out_valid=1, out_data=128'h0F0E0D0C_0B0A0908_07060504_03020100, out_bytes=16, out_last=0; after out_ready, in_ready=1.
- Same four words with in_last=1 on the 4th (in_bytes=4) → first block as above with out_last=0; then EXTRA block out_data=128'h01, out_bytes=0, out_last=1.
- Words 0x44332211 then 0xDDCCBBAA with in_bytes=3, in_last=1 → out_data=128'h0_01CCBBAA_44332211, out_bytes=7, out_last=1.
- Single word in_bytes=0, in_last=1 → out_data=128'h01, out_bytes=0, out_last=1, no EXTRA block.
- Backpressure: hold out_ready=0 for 5 cycles while driving in_valid=1 → out_data/out_bytes/out_last constant, in_ready=0, no word absorbed; block released on out_ready.
- Accept 2 words, assert clr for one cycle, then send 4 new words → the block contains only the new words. Separately, drive rst=0 mid-HOLD → out_valid=0 and out_data=0 immediately, without waiting for a clock edge.
